// File: rtl/seven_seg_scan.sv
// Time-multiplexed multi-digit seven-segment driver with frame-synchronous
// update, leading-zero suppression, per-digit blanking and anode guard time.

module seven_seg_dec (
   input  logic [3:0] nib,
   output logic [6:0] seg
);
   // active-high a..g
   always_comb begin
      seg = 7'h00;
      case (nib)
         4'h0: seg = 7'h3F;
         4'h1: seg = 7'h06;
         4'h2: seg = 7'h5B;
         4'h3: seg = 7'h4F;
         4'h4: seg = 7'h66;
         4'h5: seg = 7'h6D;
         4'h6: seg = 7'h7D;
         4'h7: seg = 7'h07;
         4'h8: seg = 7'h7F;
         4'h9: seg = 7'h6F;
         4'hA: seg = 7'h77;
         4'hB: seg = 7'h7C;
         4'hC: seg = 7'h39;
         4'hD: seg = 7'h5E;
         4'hE: seg = 7'h79;
         4'hF: seg = 7'h71;
         default: seg = 7'h00;
      endcase
   end
endmodule

module seven_seg_scan #(
   parameter int NUM_DIGITS     = 4,
   parameter int REFRESH_DIV    = 50000,
   parameter int GUARD_CYCLES   = 1,
   parameter bit SEG_ACTIVE_LOW = 1'b1,
   parameter bit AN_ACTIVE_LOW  = 1'b1,
   parameter bit LZ_BLANK       = 1'b0
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    load,
   input  logic [4*NUM_DIGITS-1:0] data_in,
   input  logic [NUM_DIGITS-1:0]   dp_in,
   input  logic [NUM_DIGITS-1:0]   blank_in,
   output logic [6:0]              seg,
   output logic                    dp,
   output logic [NUM_DIGITS-1:0]   an,
   output logic                    frame_start
);
   localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam logic [CW-1:0]         CNT_LAST = CW'(REFRESH_DIV - 1);
   localparam logic [IW-1:0]         IDX_LAST = IW'(NUM_DIGITS - 1);
   localparam logic [6:0]            SEG_OFF  = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
   localparam logic                  DP_OFF   = SEG_ACTIVE_LOW;
   localparam logic [NUM_DIGITS-1:0] AN_OFF   = {NUM_DIGITS{AN_ACTIVE_LOW}};

   logic [CW-1:0] cnt;
   logic [IW-1:0] idx;
   logic [NUM_DIGITS-1:0][3:0] pend_data, disp_data;
   logic [NUM_DIGITS-1:0]      pend_dp, pend_blank, disp_dp, disp_blank;
   logic                       pend_v;

   logic [NUM_DIGITS-1:0][6:0] dec_seg;
   logic [NUM_DIGITS:0]        upper_zero;
   logic [NUM_DIGITS-1:0]      dark;
   logic [NUM_DIGITS-1:0]      an_oh, an_n;
   logic [6:0]                 seg_n;
   logic                       dp_n, fs_n, frame_end;

   // upper_zero[k]: every nibble and dp from digit k upward is zero
   assign upper_zero[NUM_DIGITS] = 1'b1;
   for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_dig
      seven_seg_dec u_dec (.nib(disp_data[k]), .seg(dec_seg[k]));
      assign upper_zero[k] = upper_zero[k+1] & (disp_data[k] == 4'h0) & ~disp_dp[k];
      assign dark[k]       = disp_blank[k] | (LZ_BLANK & (k > 0) & upper_zero[k]);
   end

   assign frame_end = (cnt == CNT_LAST) && (idx == IDX_LAST);
   assign an_oh     = NUM_DIGITS'(1) << idx;

   always_comb begin
      seg_n = SEG_OFF;
      dp_n  = DP_OFF;
      an_n  = AN_OFF;
      fs_n  = (cnt == '0) && (idx == '0);
      if (!dark[idx]) begin
         seg_n = dec_seg[idx] ^ {7{SEG_ACTIVE_LOW}};
         dp_n  = disp_dp[idx] ^ SEG_ACTIVE_LOW;
         if (int'(cnt) >= GUARD_CYCLES)
            an_n = an_oh ^ AN_OFF;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt         <= '0;
         idx         <= '0;
         pend_v      <= 1'b0;
         pend_data   <= '0;
         pend_dp     <= '0;
         pend_blank  <= '0;
         disp_data   <= '0;
         disp_dp     <= '0;
         disp_blank  <= '0;
         seg         <= SEG_OFF;
         dp          <= DP_OFF;
         an          <= AN_OFF;
         frame_start <= 1'b0;
      end else begin
         cnt <= (cnt == CNT_LAST) ? '0 : cnt + 1'b1;
         if (cnt == CNT_LAST)
            idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
         if (load) begin
            pend_data  <= data_in;
            pend_dp    <= dp_in;
            pend_blank <= blank_in;
            pend_v     <= 1'b1;
         end
         // a load landing on the frame-end cycle bypasses the pending stage
         if (frame_end) begin
            pend_v <= 1'b0;
            if (load) begin
               disp_data  <= data_in;
               disp_dp    <= dp_in;
               disp_blank <= blank_in;
            end else if (pend_v) begin
               disp_data  <= pend_data;
               disp_dp    <= pend_dp;
               disp_blank <= pend_blank;
            end
         end
         seg         <= seg_n;
         dp          <= dp_n;
         an          <= an_n;
         frame_start <= fs_n;
      end
   end
endmodule

// File: tb/tb_seven_seg_scan.sv
// Scoreboard bench: two scanners (with and without leading-zero suppression)
// share stimulus and are checked every cycle against a frame-level model.

module tb_seven_seg_scan;
   localparam int N  = 4;
   localparam int R  = 4;
   localparam int G  = 1;
   localparam int FL = N * R;

   logic clk = 1'b0, rst = 1'b1, load = 1'b0;
   logic [15:0] data_in = '0;
   logic [3:0]  dp_in = '0, blank_in = '0;
   logic [6:0]  seg_a, seg_b;
   logic        dp_a, dp_b, fs_a, fs_b;
   logic [3:0]  an_a, an_b;

   always #5 clk = ~clk;

   seven_seg_scan #(.NUM_DIGITS(N), .REFRESH_DIV(R), .GUARD_CYCLES(G), .LZ_BLANK(1'b0)) u_a (
      .clk(clk), .rst(rst), .load(load), .data_in(data_in), .dp_in(dp_in), .blank_in(blank_in),
      .seg(seg_a), .dp(dp_a), .an(an_a), .frame_start(fs_a));
   seven_seg_scan #(.NUM_DIGITS(N), .REFRESH_DIV(R), .GUARD_CYCLES(G), .LZ_BLANK(1'b1)) u_b (
      .clk(clk), .rst(rst), .load(load), .data_in(data_in), .dp_in(dp_in), .blank_in(blank_in),
      .seg(seg_b), .dp(dp_b), .an(an_b), .frame_start(fs_b));

   typedef struct packed {
      logic [6:0] seg;
      logic       dp;
      logic [3:0] an;
      logic       fs;
   } obs_t;

   obs_t expq_a[$], expq_b[$];
   int checks = 0, errors = 0;

   // model: position within the frame plus shown/pending words
   int          m_pos = 0;
   logic [15:0] m_data = '0, p_data = '0;
   logic [3:0]  m_dp = '0, m_blank = '0, p_dp = '0, p_blank = '0;
   bit          p_v = 1'b0;
   logic [6:0]  hex_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                 7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

   function automatic obs_t predict(bit lz);
      obs_t o;
      int   d = m_pos / R;
      int   c = m_pos % R;
      bit   dark;
      dark = m_blank[d] || (lz && d > 0 && (m_data >> (4 * d)) == 0 && (m_dp >> d) == 0);
      o.fs = (m_pos == 0);
      if (dark) begin
         o.seg = 7'h7F;
         o.dp  = 1'b1;
         o.an  = 4'hF;
      end else begin
         o.seg = ~hex_tab[m_data[4*d +: 4]];
         o.dp  = ~m_dp[d];
         o.an  = (c < G) ? 4'hF : ~(4'b0001 << d);
      end
      return o;
   endfunction

   always @(posedge clk) begin
      if (rst) begin
         expq_a.push_back('{7'h7F, 1'b1, 4'hF, 1'b0});
         expq_b.push_back('{7'h7F, 1'b1, 4'hF, 1'b0});
         m_pos = 0; p_v = 1'b0;
         m_data = '0; m_dp = '0; m_blank = '0;
         p_data = '0; p_dp = '0; p_blank = '0;
      end else begin
         expq_a.push_back(predict(1'b0));
         expq_b.push_back(predict(1'b1));
         if (m_pos == FL - 1) begin
            if (load) begin
               m_data = data_in; m_dp = dp_in; m_blank = blank_in;
            end else if (p_v) begin
               m_data = p_data; m_dp = p_dp; m_blank = p_blank;
            end
            p_v = 1'b0;
         end else if (load) begin
            p_data = data_in; p_dp = dp_in; p_blank = blank_in; p_v = 1'b1;
         end
         m_pos = (m_pos + 1) % FL;
      end
   end

   task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s t=%0t actual=%h expected=%h", nm, $time, act, exp);
      end
   endtask

   always @(negedge clk) begin
      obs_t e;
      if (expq_a.size() > 0) begin
         e = expq_a.pop_front();
         chk("a.seg", {1'b0, seg_a}, {1'b0, e.seg});
         chk("a.dp",  {7'b0, dp_a},  {7'b0, e.dp});
         chk("a.an",  {4'b0, an_a},  {4'b0, e.an});
         chk("a.fs",  {7'b0, fs_a},  {7'b0, e.fs});
      end
      if (expq_b.size() > 0) begin
         e = expq_b.pop_front();
         chk("b.seg", {1'b0, seg_b}, {1'b0, e.seg});
         chk("b.dp",  {7'b0, dp_b},  {7'b0, e.dp});
         chk("b.an",  {4'b0, an_b},  {4'b0, e.an});
         chk("b.fs",  {7'b0, fs_b},  {7'b0, e.fs});
      end
   end

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic ld(input logic [15:0] d, input logic [3:0] p, input logic [3:0] b);
      data_in = d; dp_in = p; blank_in = b; load = 1'b1;
      @(negedge clk);
      load = 1'b0;
   endtask

   // park so that the next rising edge is the frame-end cycle
   task automatic to_frame_end();
      int n = 0;
      while (m_pos != FL - 1 && n < 4 * FL) begin
         @(negedge clk);
         n++;
      end
      if (m_pos != FL - 1) begin
         errors++;
         $display("FAIL frame_end_wait t=%0t actual=%0d expected=%0d", $time, m_pos, FL - 1);
      end
   endtask

   initial begin
      logic [15:0] masks [4];
      masks = '{16'hFFFF, 16'h00FF, 16'h000F, 16'h0000};
      rst = 1'b1;
      cyc(3);
      rst = 1'b0;
      ld(16'h12AF, 4'b0000, 4'b0000);
      cyc(3 * FL);
      ld(16'h1111, 4'b0000, 4'b0000);
      cyc(3);
      ld(16'h2222, 4'b0000, 4'b0000);
      cyc(2 * FL);
      to_frame_end();
      ld(16'h0005, 4'b0000, 4'b0000);
      cyc(FL + 3);
      ld(16'h0040, 4'b0000, 4'b0000);
      cyc(2 * FL);
      ld(16'h0040, 4'b1000, 4'b0000);
      cyc(2 * FL);
      ld(16'h8888, 4'b0011, 4'b0010);
      cyc(2 * FL);
      to_frame_end();
      cyc(5);
      ld(16'hBEEF, 4'b0101, 4'b0000);
      cyc(2);
      rst = 1'b1;
      cyc(1);
      rst = 1'b0;
      cyc(2 * FL);
      repeat (80) begin
         cyc($urandom_range(0, 20));
         if ($urandom_range(0, 19) == 0) begin
            rst = 1'b1;
            cyc(1);
            rst = 1'b0;
         end
         ld(16'($urandom) & masks[$urandom_range(0, 3)],
            ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0000,
            ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0000);
      end
      cyc(2 * FL);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
